// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the HI/LO multiply-divide unit: operation encodings,
// latencies and controller state type.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdop_e;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: result computed at acceptance, held in a pending
// register and committed to HI/LO after a fixed busy latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             wr_q, wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]        prod_s, prod_u;
  logic [31:0]        div_b;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  // Divisor of zero is replaced by 1 purely to keep the arithmetic defined;
  // the result is never committed in that case.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    div_b  = (b == '0) ? 32'd1 : b;
    quo_u  = a / div_b;
    rem_u  = a % div_b;
    if (a == 32'h8000_0000 && b == '1) begin
      quo_s = $signed(32'h8000_0000);
      rem_s = '0;
    end else begin
      quo_s = $signed(a) / $signed(div_b);
      rem_s = $signed(a) % $signed(div_b);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !req) begin
          case (mdop)
            MD_MULT: begin
              pend_d  = prod_s;
              wr_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYC);
              state_d = S_RUN;
            end
            MD_MULTU: begin
              pend_d  = prod_u;
              wr_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYC);
              state_d = S_RUN;
            end
            MD_DIV: begin
              pend_d  = {rem_s, quo_s};
              wr_d    = (b != '0);
              cnt_d   = CNT_W'(DIV_CYC);
              state_d = S_RUN;
            end
            MD_DIVU: begin
              pend_d  = {rem_u, quo_u};
              wr_d    = (b != '0);
              cnt_d   = CNT_W'(DIV_CYC);
              state_d = S_RUN;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .req   (req),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one accepted operation and its latency.
  task automatic model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output int lat);
    longint      sa, sb;
    longint      q, r;
    logic [63:0] p;
    sa = longint'(int'(av));
    sb = longint'(int'(bv));
    lat = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; lat = 5; end
      3'd1: begin
        p = 64'(longint'({32'd0, av}) * longint'({32'd0, bv}));
        m_hi = p[63:32]; m_lo = p[31:0]; lat = 5;
      end
      3'd2: begin
        lat = 10;
        if (bv != 0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd3: begin
        lat = 10;
        if (bv != 0) begin
          q = longint'({32'd0, av}) / longint'({32'd0, bv});
          r = longint'({32'd0, av}) % longint'({32'd0, bv});
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd4: m_hi = av;
      3'd5: m_lo = av;
      default: ;
    endcase
  endtask

  // Issue one op before the next rising edge; optionally inject a start
  // (st_cyc) and/or req (rq_cyc) during the given busy cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int st_cyc, input int rq_cyc);
    int lat;
    logic [31:0] oh, ol;
    oh = m_hi;
    ol = m_lo;
    model(op, av, bv, lat);
    start = 1'b1; req = 1'b0; mdop = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    for (int c = 1; c <= lat; c++) begin
      chk({tag, " busy"}, 64'(busy), 64'd1);
      chk({tag, " hold"}, {hi, lo}, {oh, ol});
      start = (c == st_cyc);
      req   = (c == rq_cyc);
      mdop  = 3'd0;
      @(negedge clk);
    end
    start = 1'b0; req = 1'b0;
    chk({tag, " idle"}, 64'(busy), 64'd0);
    chk({tag, " result"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 3'd0; a = '0; b = '0; req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0);
    chk("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
    chk("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu0", 3'd3, 32'h1234_5678, 32'd0, 0, 0);
    chk("divu0 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("divovf const", {hi, lo}, 64'h0000_0000_8000_0000);

    start = 1'b1; req = 1'b1; mdop = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    chk("mthi req busy", 64'(busy), 64'd0);
    chk("mthi req hi", 64'(hi), 64'(m_hi));
    run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 0, 0);
    chk("mthi const", 64'(hi), 64'h1234_5678);
    run_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0, 0, 0);
    run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1, 0, 0);
    run_op("nop7", 3'd7, 32'hDEAD_BEEF, 32'd1, 0, 0);

    run_op("div+start", 3'd2, 32'd1000, 32'd7, 2, 0);
    run_op("div+req", 3'd3, 32'hF000_0000, 32'd3, 0, 5);
    run_op("mult+both", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 3, 3);

    // Reset mid-run: asynchronous clear, pending result discarded.
    start = 1'b1; mdop = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst hilo", {hi, lo}, 64'd0);
    #1 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post rst", {31'd0, busy, hi, lo}, 64'd0);
    end

    // Start offered on the very first edge after release.
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    run_op("after rst", 3'd1, 32'd6, 32'd7, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] av, bv;
      op = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 9));
      run_op("rand", op, av, bv, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
